// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_pkg
//  Description : Shared definitions for the sequential divide path (also used
//                by the multiplier path): controller state encoding, default
//                operand width and the divide-by-zero quotient pattern.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

    // Default operand width in bits.
    localparam int DEFAULT_N = 32;

    // Quotient returned on divide-by-zero: all ones. Held at 64 bits so any
    // operand width up to 64 can take the low slice it needs.
    localparam logic [63:0] DIV0_QUOTIENT = {64{1'b1}};

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage : seq_divider_pkg
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One radix-2 restoring division step (purely combinational).
//                Shifts the next dividend bit into the partial remainder,
//                trial-subtracts the divisor magnitude and keeps the
//                difference only when it does not go negative.
//  Ports       : rem_in   - current partial remainder (N bits)
//                bit_in   - next dividend magnitude bit (MSB first)
//                dvs_mag  - divisor magnitude (unsigned)
//                rem_out  - updated partial remainder
//                q_bit    - quotient bit produced by this step
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] dvs_mag,
    output logic [N-1:0] rem_out,
    output logic         q_bit
);

    // rem_in < dvs_mag, so the shifted value is < 2*dvs_mag and needs one
    // extra bit; the kept remainder always fits back into N bits.
    logic [N:0] shifted;
    logic [N:0] diff;

    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, dvs_mag};
        q_bit   = (shifted >= {1'b0, dvs_mag});
        rem_out = q_bit ? diff[N-1:0] : shifted[N-1:0];
    end

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Multi-cycle signed divider. Operands are converted to
//                magnitudes, divided with N restoring steps, then signed.
//                Result is {remainder, quotient} in a registered output stage
//                matching the multiplier's {HI, LO} format.
//  Ports       : clk          - clock, rising edge
//                reset        - synchronous, active-low
//                en           - global stall (low freezes everything)
//                start        - begin a division (sampled only in IDLE)
//                dividend     - signed numerator (N bits)
//                divisor      - signed denominator (N bits)
//                busy         - division in progress
//                done         - one-cycle result-valid pulse
//                result       - {remainder, quotient} (2N bits)
//                div_by_zero  - divisor was zero (valid with done)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           start,
    input  logic [N-1:0]   dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] result,
    output logic           div_by_zero
);

    localparam int             CNT_W     = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    div_state_e         state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [N-1:0]       quo_q,     quo_d;      // dividend magnitude -> quotient
    logic [N-1:0]       rem_q,     rem_d;      // partial remainder
    logic [N-1:0]       dvs_mag_q, dvs_mag_d;
    logic               sign_a_q,  sign_a_d;   // dividend sign
    logic               sign_b_q,  sign_b_d;   // divisor sign
    logic               div0_q,    div0_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic [2*N-1:0]     result_q,  result_d;
    logic               dbz_q,     dbz_d;

    logic [N-1:0]       step_rem;
    logic               step_bit;

    div_step #(
        .N       (N)
    ) u_div_step (
        .rem_in  (rem_q),
        .bit_in  (quo_q[N-1]),
        .dvs_mag (dvs_mag_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_comb begin
        // Default: hold everything (this is also the whole stall behaviour).
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_mag_d = dvs_mag_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        div0_d    = div0_q;
        busy_d    = busy_q;
        done_d    = done_q;
        result_d  = result_q;
        dbz_d     = dbz_q;

        if (en) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Two's-complement negate of -2^(N-1) yields the
                        // unsigned magnitude 2^(N-1), which fits in N bits.
                        sign_a_d  = dividend[N-1];
                        sign_b_d  = divisor[N-1];
                        quo_d     = dividend[N-1] ? -dividend : dividend;
                        dvs_mag_d = divisor[N-1]  ? -divisor  : divisor;
                        rem_d     = '0;
                        cnt_d     = '0;
                        div0_d    = (divisor == '0);
                        busy_d    = 1'b1;
                        state_d   = (divisor == '0) ? SIGN : CALC;
                    end
                end
                CALC: begin
                    quo_d = {quo_q[N-2:0], step_bit};
                    rem_d = step_rem;
                    if (cnt_q == LAST_STEP) begin
                        cnt_d   = '0;
                        state_d = SIGN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SIGN: begin
                    if (div0_q) begin
                        // quo_q still holds the dividend magnitude here, so
                        // re-applying its sign reproduces the dividend.
                        quo_d = DIV0_QUOTIENT[N-1:0];
                        rem_d = sign_a_q ? -quo_q : quo_q;
                    end else begin
                        quo_d = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
                        rem_d = sign_a_q ? -rem_q : rem_q;
                    end
                    state_d = DONE;
                end
                DONE: begin
                    result_d = {rem_q, quo_q};
                    dbz_d    = div0_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_mag_q <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_mag_q <= dvs_mag_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            div0_q    <= div0_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Directed self-checking bench for seq_divider (N = 32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        en;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_divider #(.N(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts a division from a negedge and returns at the negedge on which
    // done is seen; lat = clock edges from the accepting edge to done.
    // stall_at / poke_at / rst_at inject en-low, stray start, or reset at
    // the given latency count (-1 disables). A reset returns lat = -2.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          input int stall_at, input int poke_at, input int rst_at,
                          output int lat, output logic busy1);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy1 = busy;
        lat   = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (lat == rst_at) begin
                reset = 1'b0;
                @(posedge clk);
                @(negedge clk);
                reset = 1'b1;
                lat   = -2;
                return;
            end
            if (lat == poke_at) begin
                dividend = 32'd1000;
                divisor  = 32'd3;
                start    = 1'b1;
            end
            if (lat == stall_at) begin
                en = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    lat++;
                end
                @(negedge clk);
                en = 1'b1;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b result=%h dbz=%b, want 0 0 0 0",
                     busy, done, result, div_by_zero);
        end
        reset = 1'b1; en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; logic b1;
        do_div(32'd100, 32'd7, -1, -1, -1, lat, b1);
        total++;
        if (b1 !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", b1); end
        total++;
        if (lat !== 34) begin bad++; $display("FAIL basic_latency: got %0d want 34", lat); end
        total++;
        if (result !== {32'd2, 32'd14} || div_by_zero !== 1'b0) begin
            bad++; $display("FAIL basic_result: got %h dbz=%b want %h dbz=0", result, div_by_zero, {32'd2, 32'd14});
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width: got %b want 0", done); end
    endtask

    task automatic test_signs();
        int lat; logic b1;
        do_div(-32'sd100, 32'd7, -1, -1, -1, lat, b1);
        total++;
        if (result !== {32'hFFFF_FFFE, 32'hFFFF_FFF2} || lat !== 34) begin
            bad++; $display("FAIL neg_dividend: got %h lat=%0d want fffffffefffffff2 lat=34", result, lat);
        end
        @(negedge clk);
        do_div(32'd100, -32'sd7, -1, -1, -1, lat, b1);
        total++;
        if (result !== {32'd2, 32'hFFFF_FFF2}) begin
            bad++; $display("FAIL neg_divisor: got %h want 00000002fffffff2", result);
        end
        @(negedge clk);
        do_div(-32'sd100, -32'sd7, -1, -1, -1, lat, b1);
        total++;
        if (result !== {32'hFFFF_FFFE, 32'd14}) begin
            bad++; $display("FAIL both_neg: got %h want fffffffe0000000e", result);
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat; logic b1;
        do_div(32'd5, 32'd0, -1, -1, -1, lat, b1);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL div0_latency: got %0d want 2", lat); end
        total++;
        if (result !== {32'd5, 32'hFFFF_FFFF} || div_by_zero !== 1'b1) begin
            bad++; $display("FAIL div0_result: got %h dbz=%b want 00000005ffffffff dbz=1", result, div_by_zero);
        end
        // Outputs must hold while idle with new operands on the inputs.
        dividend = 32'd77; divisor = 32'd3;
        repeat (4) @(negedge clk);
        total++;
        if (result !== {32'd5, 32'hFFFF_FFFF} || div_by_zero !== 1'b1) begin
            bad++; $display("FAIL result_hold: got %h dbz=%b want 00000005ffffffff dbz=1", result, div_by_zero);
        end
    endtask

    task automatic test_min_overflow();
        int lat; logic b1;
        do_div(32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1, lat, b1);
        total++;
        if (result !== {32'd0, 32'h8000_0000} || div_by_zero !== 1'b0) begin
            bad++; $display("FAIL min_by_minus1: got %h dbz=%b want 0000000080000000 dbz=0", result, div_by_zero);
        end
        @(negedge clk);
        do_div(32'h8000_0000, 32'd7, -1, -1, -1, lat, b1);
        total++;
        // -2147483648 / 7 = -306783378 rem -2
        if (result !== {32'hFFFF_FFFE, 32'hEDB6_DB6E}) begin
            bad++; $display("FAIL min_by_7: got %h want fffffffeedb6db6e", result);
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int lat; logic b1;
        do_div(32'd100, 32'd7, -1, 5, -1, lat, b1);
        total++;
        if (lat !== 34 || result !== {32'd2, 32'd14}) begin
            bad++; $display("FAIL start_ignored: got %h lat=%0d want 000000020000000e lat=34", result, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat; logic b1; logic seen;
        do_div(32'd100, 32'd7, -1, -1, 10, lat, b1);
        total++;
        if (lat !== -2 || busy !== 1'b0 || done !== 1'b0 || result !== 64'd0) begin
            bad++; $display("FAIL reset_abort: lat=%0d busy=%b done=%b result=%h want -2 0 0 0",
                            lat, busy, done, result);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done: got activity=%b want 0", seen); end
    endtask

    task automatic test_stall();
        int lat; logic b1;
        do_div(32'd100, 32'd7, 10, -1, -1, lat, b1);
        total++;
        if (lat !== 39 || result !== {32'd2, 32'd14}) begin
            bad++; $display("FAIL stall_latency: got lat=%0d result=%h want 39 000000020000000e", lat, result);
        end
        // Freeze while done is high: it must neither drop nor change.
        en = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL done_frozen: got %b want 1", done); end
        en = 1'b1;
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL done_after_unfreeze: got %b want 0", done); end
    endtask

    task automatic test_back_to_back();
        int lat; logic b1;
        do_div(32'd1000, 32'd3, -1, -1, -1, lat, b1);
        total++;
        if (result !== {32'd1, 32'd333}) begin
            bad++; $display("FAIL b2b_first: got %h want 000000010000014d", result);
        end
        // Launch the next division on the very cycle done is showing.
        do_div(-32'sd100, 32'd7, -1, -1, -1, lat, b1);
        total++;
        if (lat !== 34 || result !== {32'hFFFF_FFFE, 32'hFFFF_FFF2}) begin
            bad++; $display("FAIL b2b_second: got %h lat=%0d want fffffffefffffff2 lat=34", result, lat);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_min_overflow();
        test_start_while_busy();
        test_reset_abort();
        test_stall();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_divider
`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter N, default 32, operand width in bits.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, one clock; reset is synchronous and active-low.
REQ-004 SHALL have port en, input, 1, global stall; when low, all state and outputs hold.
REQ-005 SHALL have port start, input, 1, request to begin a division; sampled only in IDLE.
REQ-006 SHALL have port dividend, input, N, signed two's-complement numerator.
REQ-007 SHALL have port divisor, input, N, signed two's-complement denominator.
REQ-008 SHALL have port busy, output, 1, high from the cycle after start is accepted until done.
REQ-009 SHALL have port done, output, 1, single-cycle pulse marking result valid.
REQ-010 SHALL have port result, output, 2N, {remainder, quotient}: HI = remainder, LO = quotient.
REQ-011 SHALL have port div_by_zero, output, 1, set with done when divisor was zero.

Function
REQ-012 SHALL implement states IDLE, CALC, SIGN, DONE.
REQ-013 SHALL, in IDLE with start=1 and en=1, register dividend/divisor, record both signs, load magnitudes, go to CALC.
REQ-014 SHALL perform one radix-2 restoring step per enabled cycle in CALC, using a log2(N)+1-bit counter, for exactly N steps.
REQ-015 SHALL go CALC -> SIGN after step N; SIGN applies signs; SIGN -> DONE.
REQ-016 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-017 SHALL produce done N+2 enabled cycles after the cycle start was accepted.
REQ-018 SHALL truncate quotient toward zero; quotient negative iff operand signs differ and quotient nonzero.
REQ-019 SHALL give remainder the dividend's sign; |remainder| < |divisor|.
REQ-020 SHALL, for divisor = 0, skip CALC: IDLE -> SIGN -> DONE; quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-021 SHALL, for dividend = -2^(N-1) and divisor = -1, return quotient = -2^(N-1), remainder = 0, no flag.
REQ-022 SHALL treat the magnitude of -2^(N-1) as unsigned 2^(N-1), with no overflow in the datapath.
REQ-023 SHALL ignore start while busy; operands presented mid-operation have no effect.
REQ-024 SHALL hold result and div_by_zero stable from done until the next accepted start.
REQ-025 SHALL allow start in the same cycle the state returns to IDLE (back-to-back operation).
REQ-026 SHALL, with en low in any state, freeze state, counter, datapath and outputs; done does not repeat or drop while frozen.

Reset
REQ-027 SHALL, on a rising clk edge with reset=0, set state IDLE, counter 0, busy 0, done 0, result 0, div_by_zero 0, regardless of en.
REQ-028 SHALL abort an in-flight division on reset; no done is produced for it.

Structure
REQ-029 SHALL place the state enumeration, default N, and the divide-by-zero quotient constant (all ones) in a shared package used with the multiplier path.
REQ-030 SHALL use one combinational sub-module, div_step: shift partial remainder, trial-subtract the divisor magnitude, output the new partial remainder and quotient bit.
REQ-031 SHALL keep the output register stage inside seq_divider so result matches the registered {HI,LO} format of the multiplier.

Verification
REQ-032 SHALL check 100 / 7 -> result LO = 14, HI = 2, done exactly 34 cycles after the start cycle (N=32).
REQ-033 SHALL check -100 / 7 -> LO = 0xFFFFFFF2, HI = 0xFFFFFFFE; and 100 / -7 -> LO = 0xFFFFFFF2, HI = 2.
REQ-034 SHALL check 5 / 0 -> LO = 0xFFFFFFFF, HI = 5, div_by_zero = 1, done 2 cycles after the start cycle.
REQ-035 SHALL check 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0, div_by_zero = 0.
REQ-036 SHALL check reset=0 asserted at CALC cycle 10 -> next cycle busy = 0, result = 0, no done; a start pulsed while busy is ignored.
REQ-037 SHALL check en held low for 5 cycles mid-CALC -> done delayed by exactly 5 cycles and the result unchanged (100 / 7 -> 14, 2).
